buffer_sched: RTL and testbench

- Controller that sequences one input buffer feeding the convolution PE array.
- Accepts a job of N input writes from the upstream loader and gates them into the buffer as writes (`buf_wen`) until the buffer reports full.
- Drains the buffer to the PE array for a fixed number of beats, clears it, and repeats until all N writes are consumed. Then pulses `done`.
- Sits between the DMA/loader, the buffer, and the PE array; contains no datapath, only control.

---
 rtl/buffer_sched_if.sv | 36 +++
 rtl/buffer_sched.sv | 118 +++++++++++
 tb/tb_buffer_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_sched_if.sv
// Handshake and buffer-control bundle between buffer_sched and its
// loader / input buffer / PE-array neighbours.
interface buffer_sched_if #(
   parameter int OUT_NUM_OF_SET = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic                      buf_wen;
   logic                      buf_clr;
   logic                      buf_full;
   logic [OUT_NUM_OF_SET-1:0] buf_valid;
   logic                      pe_valid;
   logic                      pe_ready;

   modport master (
      input  in_valid,
      input  buf_full,
      input  buf_valid,
      input  pe_ready,
      output in_ready,
      output buf_wen,
      output buf_clr,
      output pe_valid
   );

   modport slave (
      output in_valid,
      output buf_full,
      output buf_valid,
      output pe_ready,
      input  in_ready,
      input  buf_wen,
      input  buf_clr,
      input  pe_valid
   );
endinterface

// File: rtl/buffer_sched.sv
// Fill/drain sequencer for one PE-array input buffer: gates loader
// writes into the buffer, drains it to the PEs, clears, repeats.
module buffer_sched #(
   parameter int OUT_NUM_OF_SET = 2,
   parameter int DRAIN_BEATS    = 4,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] cfg_num_writes,
   buffer_sched_if.master   bus,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] writes_left,
   output logic [CNT_W-1:0] pass_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FILL,
      DRAIN,
      DONE
   } state_t;

   state_t                    state;
   logic [CNT_W-1:0]          drain_cnt;
   logic [OUT_NUM_OF_SET-1:0] sets;
   logic                      in_fill;
   logic                      in_drain;
   logic                      hs;
   logic                      last_beat;
   logic                      last_write;
   logic                      wl_zero;
   logic                      clr_q;

   assign sets     = bus.buf_valid;
   assign in_fill  = (state == FILL);
   assign in_drain = (state == DRAIN);
   assign wl_zero  = (writes_left == '0);

   assign bus.in_ready = in_fill & ~bus.buf_full & ~wl_zero;
   assign bus.buf_wen  = bus.in_valid & bus.in_ready;
   assign bus.pe_valid = in_drain & (&sets);
   assign bus.buf_clr  = clr_q;

   assign hs         = bus.pe_valid & bus.pe_ready;
   assign last_beat  = hs & (drain_cnt == CNT_W'(DRAIN_BEATS - 1));
   assign last_write = bus.buf_wen & (writes_left == CNT_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         writes_left <= '0;
         pass_cnt    <= '0;
         drain_cnt   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         clr_q       <= 1'b0;
      end else begin
         clr_q <= 1'b0;
         done  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  writes_left <= cfg_num_writes;
                  pass_cnt    <= '0;
                  busy        <= 1'b1;
                  if (cfg_num_writes == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= CLEAR;
                     clr_q <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               drain_cnt <= '0;
               state     <= FILL;
            end
            FILL: begin
               if (bus.buf_wen) begin
                  writes_left <= writes_left - CNT_W'(1);
               end
               if (bus.buf_full || wl_zero || last_write) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_beat) begin
                  drain_cnt <= '0;
                  pass_cnt  <= pass_cnt + CNT_W'(1);
                  if (!wl_zero) begin
                     state <= CLEAR;
                     clr_q <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else if (hs) begin
                  drain_cnt <= drain_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_buffer_sched.sv
// Randomised bench for buffer_sched: a buffer-fill model drives buf_full
// and each job's event trace is compared with one derived from N/capacity.
module tb_buffer_sched;
   localparam int SETS = 2;
   localparam int DB   = 4;
   localparam int CW   = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic [CW-1:0] cfg_num_writes;
   logic          busy;
   logic          done;
   logic [CW-1:0] writes_left;
   logic [CW-1:0] pass_cnt;

   int n_cmp;
   int n_bad;
   int iv_pat[$];

   buffer_sched_if #(.OUT_NUM_OF_SET(SETS)) bus ();

   buffer_sched #(
      .OUT_NUM_OF_SET(SETS),
      .DRAIN_BEATS   (DB),
      .CNT_W         (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .cfg_num_writes(cfg_num_writes),
      .bus           (bus.master),
      .busy          (busy),
      .done          (done),
      .writes_left   (writes_left),
      .pass_cnt      (pass_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One job: 0=clr, 1=write, 2=PE handshake, 3=done.
   task automatic run_job(input int n, input int cap, input bit rv,
                          input bit rp, input bit stall, input bit hold,
                          input string tag);
      int  obs[$];
      int  exp_q[$];
      int  rem, k, level, acc, hs, cyc, exp_cyc;
      bit  fin, det, same;
      logic [SETS-1:0] all1;
      all1 = '1;
      det = !rv && !rp && !stall && (iv_pat.size() == 0);
      rem = n;
      exp_cyc = 1;
      while (rem > 0) begin
         k = (rem < cap) ? rem : cap;
         exp_q.push_back(0);
         repeat (k) exp_q.push_back(1);
         repeat (DB) exp_q.push_back(2);
         rem -= k;
         exp_cyc += 1 + k + DB + ((rem > 0) ? 1 : 0);
      end
      exp_q.push_back(3);

      @(negedge clk);
      start          = 1'b1;
      cfg_num_writes = CW'(n);
      bus.in_valid   = 1'b0;
      bus.pe_ready   = 1'b0;
      bus.buf_valid  = '0;
      bus.buf_full   = 1'b0;
      level = 0; acc = 0; hs = 0; cyc = 0; fin = 0;

      while (!fin && cyc < 2000) begin
         @(negedge clk);
         start          = hold;
         cfg_num_writes = hold ? CW'($urandom) : CW'(n);
         if (iv_pat.size() > 0) bus.in_valid = iv_pat.pop_front() != 0;
         else bus.in_valid = rv ? ($urandom % 2 == 1) : 1'b1;
         bus.pe_ready = rp ? ($urandom % 2 == 1) : 1'b1;
         if (stall) bus.buf_valid = (cyc % 5 < 3) ? 2'b01 : 2'b11;
         else bus.buf_valid = rp ? SETS'($urandom) : all1;
         bus.buf_full = (level >= cap);
         #1;
         n_cmp++;
         if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy cyc=%0d got %b want 1", tag, cyc, busy);
         end
         n_cmp++;
         if (writes_left !== CW'(n - acc)) begin
            n_bad++;
            $display("FAIL %s writes_left cyc=%0d got %0d want %0d",
                     tag, cyc, writes_left, n - acc);
         end
         n_cmp++;
         if (pass_cnt !== CW'(hs / DB)) begin
            n_bad++;
            $display("FAIL %s pass_cnt cyc=%0d got %0d want %0d",
                     tag, cyc, pass_cnt, hs / DB);
         end
         n_cmp++;
         if (bus.buf_wen !== (bus.in_valid & bus.in_ready)) begin
            n_bad++;
            $display("FAIL %s buf_wen cyc=%0d got %b want %b", tag, cyc,
                     bus.buf_wen, bus.in_valid & bus.in_ready);
         end
         if (bus.buf_full) begin
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.buf_wen !== 1'b0) begin
               n_bad++;
               $display("FAIL %s full_gate cyc=%0d got rdy=%b wen=%b want 0",
                        tag, cyc, bus.in_ready, bus.buf_wen);
            end
         end
         if (bus.buf_valid !== all1) begin
            n_cmp++;
            if (bus.pe_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL %s pe_valid_sets cyc=%0d got %b want 0",
                        tag, cyc, bus.pe_valid);
            end
         end
         n_cmp++;
         if (bus.buf_wen && (bus.buf_clr || bus.pe_valid)) begin
            n_bad++;
            $display("FAIL %s wen_excl cyc=%0d got clr=%b pv=%b want 0",
                     tag, cyc, bus.buf_clr, bus.pe_valid);
         end
         if (bus.buf_clr) obs.push_back(0);
         if (bus.buf_wen) obs.push_back(1);
         if (bus.pe_valid && bus.pe_ready) obs.push_back(2);
         if (done) begin
            obs.push_back(3);
            fin = 1;
         end
         if (bus.buf_clr) level = 0;
         if (bus.buf_wen) begin
            level++;
            acc++;
         end
         if (bus.pe_valid && bus.pe_ready) hs++;
         cyc++;
      end
      start = 1'b0;

      n_cmp++;
      if (!fin) begin
         n_bad++;
         $display("FAIL %s timeout got no done want done", tag);
      end
      same = (obs.size() == exp_q.size());
      if (same) foreach (obs[i]) if (obs[i] != exp_q[i]) same = 0;
      n_cmp++;
      if (!same) begin
         n_bad++;
         $display("FAIL %s trace got %0d events want %0d (n=%0d cap=%0d)",
                  tag, obs.size(), exp_q.size(), n, cap);
      end
      if (det) begin
         n_cmp++;
         if (cyc != exp_cyc) begin
            n_bad++;
            $display("FAIL %s cycles got %0d want %0d", tag, cyc, exp_cyc);
         end
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s idle_after got busy=%b done=%b want 0 0",
                  tag, busy, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0;
      cfg_num_writes = '0;
      bus.in_valid = 1'b0;
      bus.buf_full = 1'b0;
      bus.buf_valid = '0;
      bus.pe_ready = 1'b0;
      #23;
      n_cmp++;
      if ({busy, done, bus.buf_clr, bus.in_ready, bus.buf_wen,
           bus.pe_valid} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_outs got %b want 000000",
                  {busy, done, bus.buf_clr, bus.in_ready, bus.buf_wen,
                   bus.pe_valid});
      end
      n_cmp++;
      if (writes_left !== '0 || pass_cnt !== '0) begin
         n_bad++;
         $display("FAIL reset_cnt got wl=%0d pc=%0d want 0 0",
                  writes_left, pass_cnt);
      end
      @(negedge clk);
      rst = 1'b1;
      // park a job in FILL with no input, then reset between edges
      @(negedge clk);
      start = 1'b1;
      cfg_num_writes = CW'(8);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || writes_left !== CW'(8)) begin
         n_bad++;
         $display("FAIL mid_fill got rdy=%b wl=%0d want 1 8",
                  bus.in_ready, writes_left);
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || writes_left !== '0 || bus.in_ready !== 1'b0 ||
          bus.buf_clr !== 1'b0) begin
         n_bad++;
         $display("FAIL async_rst got busy=%b wl=%0d rdy=%b clr=%b want 0",
                  busy, writes_left, bus.in_ready, bus.buf_clr);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single_pass();
      run_job(4, 4, 0, 0, 0, 0, "single");
   endtask

   task automatic test_multi_pass();
      run_job(6, 4, 0, 0, 0, 0, "multi");
      run_job(9, 3, 0, 0, 0, 0, "multi3");
   endtask

   task automatic test_backpressure();
      iv_pat = '{0, 1, 0, 1, 1};
      run_job(4, 4, 0, 0, 0, 0, "bp_pat");
      run_job(8, 4, 1, 0, 0, 0, "bp_rand");
   endtask

   task automatic test_drain_stall();
      run_job(4, 4, 0, 0, 1, 0, "stall");
      run_job(6, 4, 1, 1, 1, 0, "stall_rand");
   endtask

   task automatic test_zero_job();
      run_job(0, 4, 0, 0, 0, 0, "zero");
   endtask

   task automatic test_start_ignored();
      run_job(6, 4, 0, 0, 0, 1, "start_hold");
      run_job(5, 2, 1, 1, 0, 1, "start_hold_rand");
   endtask

   task automatic test_random();
      for (int j = 0; j < 10; j++) begin
         run_job($urandom_range(0, 10), $urandom_range(1, 5), 1, 1,
                 0, $urandom_range(0, 1) == 1, "random");
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_single_pass();
      test_multi_pass();
      test_backpressure();
      test_drain_stall();
      test_zero_job();
      test_start_ignored();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
